// File: rtl/fp_sched_pkg.sv
// -----------------------------------------------------------------------------
// fp_sched_pkg
// Shared types for the floating-point writeback scheduler.
//   fp_class_e   : operation class (ADD/MUL/FMA). Encoding 3 is reserved.
//   sched_slot_t : control half of one latency-reservation slot (valid + class).
//                  ROB tag and destination register widths depend on module
//                  parameters, so those fields live in parallel arrays in the core.
//   lat_of()     : issue-to-writeback latency of a class.
// -----------------------------------------------------------------------------
package fp_sched_pkg;

  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_MUL = 2'd1,
    FP_FMA = 2'd2,
    FP_RSV = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic      valid;
    fp_class_e cls;
  } sched_slot_t;

  localparam sched_slot_t SLOT_EMPTY = '{valid: 1'b0, cls: FP_ADD};

  // Reserved class maps to the FMA latency; callers gate it out of issue.
  function automatic int lat_of(fp_class_e c, int add_lat, int mul_lat, int fma_lat);
    case (c)
      FP_ADD:  return add_lat;
      FP_MUL:  return mul_lat;
      default: return fma_lat;
    endcase
  endfunction

endpackage

// File: rtl/fp_pipe_sched_if.sv
// -----------------------------------------------------------------------------
// fp_pipe_sched_if
// Issue / redirect / wakeup / writeback bundle of the FP writeback scheduler.
//   master : issue-queue / backend side (drives issue and redirect).
//   slave  : the scheduler (drives ready, wakeup, writeback, busy).
// Signals:
//   iss_valid, iss_class[1:0], iss_rob[ROB_WIDTH:0], iss_rd  : issue request
//   iss_ready[2:0]                                          : per-class permission
//   redirect, redirect_rob[ROB_WIDTH:0]                     : backend redirect
//   wakeup_en, wakeup_rd                                    : early register wakeup
//   wb_en, wb_class, wb_rob, wb_rd                          : writeback port
//   busy                                                    : any op in flight
// -----------------------------------------------------------------------------
interface fp_pipe_sched_if #(
  parameter int ROB_WIDTH  = 6,
  parameter int PREG_WIDTH = 7
);
  logic                  iss_valid;
  logic [1:0]            iss_class;
  logic [ROB_WIDTH:0]    iss_rob;
  logic [PREG_WIDTH-1:0] iss_rd;
  logic [2:0]            iss_ready;
  logic                  redirect;
  logic [ROB_WIDTH:0]    redirect_rob;
  logic                  wakeup_en;
  logic [PREG_WIDTH-1:0] wakeup_rd;
  logic                  wb_en;
  logic [1:0]            wb_class;
  logic [ROB_WIDTH:0]    wb_rob;
  logic [PREG_WIDTH-1:0] wb_rd;
  logic                  busy;

  modport master (
    output iss_valid, iss_class, iss_rob, iss_rd, redirect, redirect_rob,
    input  iss_ready, wakeup_en, wakeup_rd, wb_en, wb_class, wb_rob, wb_rd, busy
  );

  modport slave (
    input  iss_valid, iss_class, iss_rob, iss_rd, redirect, redirect_rob,
    output iss_ready, wakeup_en, wakeup_rd, wb_en, wb_class, wb_rob, wb_rd, busy
  );
endinterface

// File: rtl/rob_age_cmp.sv
// -----------------------------------------------------------------------------
// rob_age_cmp
// Combinational ROB age compare on wrap-flagged tags (flag is the MSB).
//   i_a, i_b  : tags, ROB_WIDTH+1 bits
//   o_younger : 1 when i_a is younger than i_b
// Same flag: larger index is younger. Different flag: i_a has wrapped past
// i_b, so the smaller index is the younger one.
// -----------------------------------------------------------------------------
module rob_age_cmp #(
  parameter int ROB_WIDTH = 6
) (
  input  logic [ROB_WIDTH:0] i_a,
  input  logic [ROB_WIDTH:0] i_b,
  output logic               o_younger
);
  logic w_same_flag;

  assign w_same_flag = (i_a[ROB_WIDTH] == i_b[ROB_WIDTH]);
  assign o_younger   = w_same_flag ? (i_a[ROB_WIDTH-1:0] > i_b[ROB_WIDTH-1:0])
                                   : (i_a[ROB_WIDTH-1:0] < i_b[ROB_WIDTH-1:0]);
endmodule

// File: rtl/fp_pipe_sched.sv
// -----------------------------------------------------------------------------
// fp_pipe_sched
// Writeback scheduler for FADD/FMUL/FMA sharing one writeback port. A
// latency-reservation shift register holds one slot per future writeback
// cycle: slot[k] writes back k cycles from now, slot[0] drives the port.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : fp_pipe_sched_if.slave (issue, redirect, wakeup, writeback, busy)
// Parameters:
//   ROB_WIDTH, PREG_WIDTH         : tag index / physical register widths
//   ADD_LAT, MUL_LAT, FMA_LAT     : issue-to-writeback latencies
//                                   (FMA_LAT >= ADD_LAT, MUL_LAT >= 1)
//   WAKEUP_AHEAD                  : wakeup lead, < min(ADD_LAT, MUL_LAT)
// -----------------------------------------------------------------------------
module fp_pipe_sched
  import fp_sched_pkg::*;
#(
  parameter int ROB_WIDTH    = 6,
  parameter int PREG_WIDTH   = 7,
  parameter int ADD_LAT      = 2,
  parameter int MUL_LAT      = 3,
  parameter int FMA_LAT      = 5,
  parameter int WAKEUP_AHEAD = 1
) (
  input logic            clk,
  input logic            rst,
  fp_pipe_sched_if.slave bus
);
  localparam int TW   = ROB_WIDTH + 1;
  localparam int IDXW = $clog2(FMA_LAT + 1);

  // Slot state
  sched_slot_t           r_ctl [FMA_LAT];
  logic [TW-1:0]         r_rob [FMA_LAT];
  logic [PREG_WIDTH-1:0] r_rd  [FMA_LAT];

  // Shift sources (slot array plus an always-empty slot above the top)
  sched_slot_t           w_src_ctl [FMA_LAT+1];
  logic [TW-1:0]         w_src_rob [FMA_LAT+1];
  logic [PREG_WIDTH-1:0] w_src_rd  [FMA_LAT+1];

  // Next state
  sched_slot_t           w_ctl_nxt [FMA_LAT];
  logic [TW-1:0]         w_rob_nxt [FMA_LAT];
  logic [PREG_WIDTH-1:0] w_rd_nxt  [FMA_LAT];

  logic [FMA_LAT-1:0] w_valid;
  logic [FMA_LAT-1:0] w_kill;
  logic [FMA_LAT:0]   w_valid_ext;
  logic [2:0]         w_iss_ready;
  logic [3:0]         w_ready_ext;
  logic               w_iss_younger;
  logic               w_iss_kill;
  logic               w_accept;
  fp_class_e          w_iss_cls;
  int                 w_ins_idx;

  // ---------------------------------------------------------------------------
  // Redirect kill: one age comparator per slot, one for the issue port.
  // The redirecting tag itself is not younger than itself, so it survives.
  // ---------------------------------------------------------------------------
  for (genvar gk = 0; gk < FMA_LAT; gk++) begin : g_slot
    logic w_younger;

    rob_age_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_age (
      .i_a       (r_rob[gk]),
      .i_b       (bus.redirect_rob),
      .o_younger (w_younger)
    );

    assign w_valid[gk] = r_ctl[gk].valid;
    assign w_kill[gk]  = bus.redirect & w_younger;
  end

  rob_age_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_iss_age (
    .i_a       (bus.iss_rob),
    .i_b       (bus.redirect_rob),
    .o_younger (w_iss_younger)
  );

  assign w_iss_kill = bus.redirect & w_iss_younger;

  // ---------------------------------------------------------------------------
  // Issue readiness. A class of latency L lands in slot[L-1] after the shift,
  // which is where slot[L] currently sits, so slot[L] must be free. Index
  // FMA_LAT is the empty slot above the top and always reads free. Valids are
  // taken before kill, which can only refuse an issue that would have fit.
  // ---------------------------------------------------------------------------
  assign w_valid_ext = {1'b0, w_valid};

  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (here unconditionally per loop pass); a missed path infers a latch.
  always_comb begin
    w_iss_ready = '0;
    for (int c = 0; c < 3; c++) begin
      w_iss_ready[c] = ~w_valid_ext[IDXW'(lat_of(fp_class_e'(2'(c)), ADD_LAT, MUL_LAT, FMA_LAT))];
    end
  end

  assign w_ready_ext = {1'b0, w_iss_ready};
  assign w_iss_cls   = fp_class_e'(bus.iss_class);
  assign w_accept    = bus.iss_valid & (w_iss_cls != FP_RSV)
                     & w_ready_ext[bus.iss_class] & ~w_iss_kill;
  assign w_ins_idx   = lat_of(w_iss_cls, ADD_LAT, MUL_LAT, FMA_LAT) - 1;

  // ---------------------------------------------------------------------------
  // Shift down by one with killed entries dropped; an accepted issue lands in
  // slot[L-1]. That slot's shift source is slot[L], known free when accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < FMA_LAT; k++) begin
      w_src_ctl[k]       = r_ctl[k];
      w_src_ctl[k].valid = r_ctl[k].valid & ~w_kill[k];
      w_src_rob[k]       = r_rob[k];
      w_src_rd[k]        = r_rd[k];
    end
    w_src_ctl[FMA_LAT] = SLOT_EMPTY;
    w_src_rob[FMA_LAT] = '0;
    w_src_rd[FMA_LAT]  = '0;

    for (int k = 0; k < FMA_LAT; k++) begin
      w_ctl_nxt[k] = w_src_ctl[k+1];
      w_rob_nxt[k] = w_src_rob[k+1];
      w_rd_nxt[k]  = w_src_rd[k+1];
      if (w_accept && (w_ins_idx == k)) begin
        w_ctl_nxt[k] = '{valid: 1'b1, cls: w_iss_cls};
        w_rob_nxt[k] = bus.iss_rob;
        w_rd_nxt[k]  = bus.iss_rd;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the slot array is a handful of flops, not a RAM, so it is reset
      // in full; this also forces the tag/rd outputs to 0 during reset.
      for (int k = 0; k < FMA_LAT; k++) begin
        r_ctl[k] <= SLOT_EMPTY;
        r_rob[k] <= '0;
        r_rd[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < FMA_LAT; k++) begin
        r_ctl[k] <= w_ctl_nxt[k];
        r_rob[k] <= w_rob_nxt[k];
        r_rd[k]  <= w_rd_nxt[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Redirect masks wakeup and writeback in the same cycle.
  // ---------------------------------------------------------------------------
  assign bus.iss_ready = w_iss_ready;
  assign bus.wb_en     = r_ctl[0].valid & ~w_kill[0];
  assign bus.wb_class  = r_ctl[0].cls;
  assign bus.wb_rob    = r_rob[0];
  assign bus.wb_rd     = r_rd[0];
  assign bus.wakeup_en = r_ctl[WAKEUP_AHEAD].valid & ~w_kill[WAKEUP_AHEAD];
  assign bus.wakeup_rd = r_rd[WAKEUP_AHEAD];
  assign bus.busy      = |w_valid;

endmodule

// File: doc/fp_pipe_sched.md
# fp_pipe_sched

Parametrised writeback scheduler for the floating-point execute cluster. Tracks in-flight FADD, FMUL and FMA operations of differing fixed latencies that share one writeback port. Uses a latency-reservation shift register to:
- refuse issue on a writeback collision;
- emit early register wakeup;
- squash entries younger than a backend redirect.

The datapath (multiplier/adder) is external. This block supplies its control, tags and result select.

## Interface
Parameters:
- ROB_WIDTH, 6: ROB index width excluding the wrap flag; tags are ROB_WIDTH+1 bits with the flag as the MSB.
- PREG_WIDTH, 7: physical register index width.
- ADD_LAT, 2: FADD/FSUB issue-to-writeback cycles; must be ≥1.
- MUL_LAT, 3: FMUL latency; must be ≥1.
- FMA_LAT, 5: fused latency; must be ≥ max(ADD_LAT, MUL_LAT).
- WAKEUP_AHEAD, 1: wakeup lead before writeback; must be < min(ADD_LAT, MUL_LAT).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-low.
- iss_valid  in  1  issue request.
- iss_class  in  2  fp_class_e: ADD=0, MUL=1, FMA=2; 3 is reserved and treated as not valid.
- iss_rob  in  ROB_WIDTH+1  ROB tag.
- iss_rd  in  PREG_WIDTH  destination physical register.
- iss_ready  out  3  per-class issue permission, indexed by class.
- redirect  in  1  backend redirect.
- redirect_rob  in  ROB_WIDTH+1  redirecting ROB tag.
- wakeup_en  out  1  wakeup valid.
- wakeup_rd  out  PREG_WIDTH  register being woken.
- wb_en  out  1  writeback valid.
- wb_class  out  2  result-mux select for the datapath.
- wb_rob  out  ROB_WIDTH+1  writeback ROB tag.
- wb_rd  out  PREG_WIDTH  writeback destination register.
- busy  out  1  any slot valid; used for fence and drain.

## Operation
- State: slot[0..FMA_LAT-1], each holding {valid, class, rob, rd}.
  - slot[k] writes back k cycles after the current one.
  - slot[0] drives wb_* combinationally.
- Each cycle slots shift down: slot[k] ← slot[k+1], and slot[FMA_LAT-1] is refilled empty unless written.
- Issue latency L = lat(iss_class).
  - iss_ready[c] = 1 iff slot[lat(c)] is not valid; index FMA_LAT counts as always free.
  - Readiness uses pre-kill valids, which is conservative.
- Accept = iss_valid & iss_ready[iss_class] & class≠3 & ¬kill(iss_rob). Accept writes slot[L-1] with valid=1.
  - Issuing with iss_ready low is a protocol error; the request is ignored and no slot changes.
- Younger test: younger(a,b) = (a.flag==b.flag) ? a.idx>b.idx : a.idx<b.idx.
- Kill(x) = redirect & younger(x, redirect_rob). The redirecting tag itself survives.
- When redirect is high, every killed slot clears valid while shifting.
  - wb_en and wakeup_en are masked in the same cycle for killed entries.
- wakeup_en = slot[WAKEUP_AHEAD].valid & ¬kill; wakeup_rd = slot[WAKEUP_AHEAD].rd.
- With WAKEUP_AHEAD=0, wakeup coincides with wb_en.
- wb_en = slot[0].valid & ¬kill(slot[0].rob).
- busy = OR of all slot valids before kill.

## Timing
- Issue accepted in cycle t: wb_en in cycle t+L, wakeup_en in cycle t+L-WAKEUP_AHEAD.
- Throughput:
  - one issue per cycle;
  - back-to-back same-class issues never conflict;
  - FMA issued at t blocks an ADD at t+FMA_LAT-ADD_LAT.
- Redirect effect is same-cycle on outputs and next-edge on state.
- There is no pending or stall state; a refused issue simply retries.
- Reset (rst=0, asynchronous): all slot valids are 0.
  - Outputs during and after reset: wb_en=0, wakeup_en=0, busy=0, iss_ready=3'b111.
  - Tag and rd outputs reset to 0.
- Reset asserted mid-operation drops all in-flight ops; no writeback occurs for them.
- Tag wrap: correctness relies only on the flag compare; ROB occupancy is ≤ 2^ROB_WIDTH.

## Structure
- Package fp_sched_pkg: fp_class_e, sched_slot_t struct, lat_of() function.
- Sub-module rob_age_cmp (ROB_WIDTH): combinational younger(a,b).
  - One instance per slot, plus one for the issue port.
- Core: slot array, shift/insert logic, ready/wakeup/wb decode.
- Total RTL is roughly 200 lines.

## Test plan
All scenarios use default parameters.
- Single FMA, rob=0x05, rd=0x12, issued cycle 10 → wakeup_en/wakeup_rd=0x12 in cycle 14; wb_en, wb_class=2, wb_rob=0x05 in cycle 15; busy high in cycles 11–15.
- Collision: FMA at cycle 0 → iss_ready[ADD]=0 in cycle 3. An ADD held valid through cycle 3 is accepted in cycle 4 and writes back in cycle 6; the FMA writes back in cycle 5.
- Redirect: issue robs 0x03, 0x04, 0x06 as MUL in cycles 0–2; redirect_rob=0x04 in cycle 2 → only 0x03 (cycle 3) and 0x04 (cycle 4) write back. The issue of 0x06 is itself killed, and no wakeup for 0x06 appears.
- Wrap compare: slot rob=0x41 (flag 1, idx 1), redirect_rob=0x3E (flag 0, idx 62) → the slot is killed. With redirect_rob=0x42, the slot survives.
- Async reset: drop rst during cycle 2 with three ops in flight → wb_en, wakeup_en, busy go to 0 immediately without a clock edge; after release, iss_ready=3'b111 and no stale writeback occurs.
- Random mixed classes for 10k cycles against a scoreboard model → exactly one writeback per accepted, unkilled op, at issue+lat.
